// File: rtl/bsg_token_credit_pkg.sv
//==============================================================================
// Module      : bsg_token_credit_pkg
// Description : Shared types and sizing helpers for the token-credit transmitter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package bsg_token_credit_pkg;

    typedef enum logic [0:0] {
        e_init = 1'b0,
        e_run  = 1'b1
    } state_e;

    // Counter must represent 0..credits inclusive.
    function automatic int credit_cnt_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_token_credit_tx_if.sv
//==============================================================================
// Module      : bsg_token_credit_tx_if
// Description : Core-side handshake and outbound channel word group.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bsg_token_credit_tx_if #(
    parameter int width_p = 8
) ();

    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               valid_o;
    logic [width_p-1:0] data_o;

    modport slave (
        input  v_i,
        input  data_i,
        output ready_o,
        output valid_o,
        output data_o
    );

    modport master (
        output v_i,
        output data_i,
        input  ready_o,
        input  valid_o,
        input  data_o
    );

endinterface

`default_nettype wire

// File: rtl/bsg_two_fifo.sv
//==============================================================================
// Module      : bsg_two_fifo
// Description : Two-entry first-word-fall-through FIFO, valid/ready in, valid/yumi out.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  wire logic               clk_i,
    input  wire logic               reset_i,
    output logic                    ready_o,
    input  wire logic [width_p-1:0] data_i,
    input  wire logic               v_i,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  wire logic               yumi_i
);

    logic [width_p-1:0] r_mem [2];
    logic               r_head;
    logic               r_tail;
    logic [1:0]         r_count;
    logic               w_enq;
    logic               w_deq;

    assign ready_o = (r_count != 2'd2);
    assign v_o     = (r_count != 2'd0);
    assign data_o  = r_mem[r_head];
    assign w_enq   = v_i & ready_o;
    assign w_deq   = yumi_i & v_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_enq) r_tail <= ~r_tail;
            if (w_deq) r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) r_mem[r_tail] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/bsg_token_credit_tx.sv
//==============================================================================
// Module      : bsg_token_credit_tx
// Description : Credit-gated transmit stage; buffers core words and releases
//               them to the channel while downstream credits remain.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bsg_token_credit_tx
    import bsg_token_credit_pkg::*;
#(
    parameter int width_p           = 8,
    parameter int credits_p         = 32,
    parameter int tokens_per_edge_p = 4,
    localparam int c_cnt_w          = credit_cnt_width(credits_p)
) (
    input  wire logic              clk_i,
    input  wire logic              async_reset_n_i,
    input  wire logic              enable_i,
    bsg_token_credit_tx_if.slave   bus,
    input  wire logic              token_sync_i,
    output logic [c_cnt_w-1:0]     credits_o,
    output logic                   credit_overflow_o
);

    localparam logic [c_cnt_w-1:0] c_credits_max     = c_cnt_w'(credits_p);
    localparam logic [c_cnt_w:0]   c_credits_max_ext = (c_cnt_w + 1)'(credits_p);
    localparam logic [c_cnt_w:0]   c_tok_inc         = (c_cnt_w + 1)'(tokens_per_edge_p);

    state_e               r_state;
    state_e               w_state_next;
    logic                 r_token;
    logic [c_cnt_w-1:0]   r_credits;
    logic [c_cnt_w-1:0]   w_credits_next;
    logic [c_cnt_w:0]     w_credit_sum;
    logic                 r_overflow;
    logic                 w_overflow_set;
    logic                 r_valid;
    logic [width_p-1:0]   r_data;

    logic                 w_tok_edge;
    logic                 w_ready;
    logic                 w_send;
    logic                 w_fifo_flush;
    logic                 w_fifo_ready;
    logic                 w_fifo_v;
    logic [width_p-1:0]   w_fifo_data;

    assign w_tok_edge   = token_sync_i ^ r_token;
    assign w_ready      = (r_state == e_run) & w_fifo_ready;
    // The disabling edge already stops issue so nothing leaks out after enable_i drops.
    assign w_send       = (r_state == e_run) & enable_i & w_fifo_v & (r_credits != '0);
    assign w_fifo_flush = (r_state == e_init) | (w_state_next == e_init);

    bsg_two_fifo #(
        .width_p (width_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (w_fifo_flush),
        .ready_o (w_fifo_ready),
        .data_i  (bus.data_i),
        .v_i     (bus.v_i & w_ready),
        .v_o     (w_fifo_v),
        .data_o  (w_fifo_data),
        .yumi_i  (w_send)
    );

    always_comb begin
        w_state_next   = r_state;
        w_credits_next = r_credits;
        w_overflow_set = 1'b0;
        w_credit_sum   = {1'b0, r_credits} + (w_tok_edge ? c_tok_inc : '0)
                         - {{c_cnt_w{1'b0}}, w_send};
        case (r_state)
            e_init: begin
                w_credits_next = c_credits_max;
                if (enable_i) w_state_next = e_run;
            end
            e_run: begin
                if (!enable_i) begin
                    w_state_next   = e_init;
                    w_credits_next = c_credits_max;
                end else if (w_credit_sum > c_credits_max_ext) begin
                    w_credits_next = c_credits_max;
                    w_overflow_set = 1'b1;
                end else begin
                    w_credits_next = w_credit_sum[c_cnt_w-1:0];
                end
            end
            default: w_state_next = e_init;
        endcase
    end

    always_ff @(posedge clk_i or negedge async_reset_n_i) begin
        if (!async_reset_n_i) begin
            r_state    <= e_init;
            r_token    <= 1'b0;
            r_credits  <= c_credits_max;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_token   <= token_sync_i;
            r_credits <= w_credits_next;
            r_valid   <= w_send;
            if (w_overflow_set) r_overflow <= 1'b1;
            if (w_send)         r_data     <= w_fifo_data;
        end
    end

    assign bus.ready_o        = w_ready;
    assign bus.valid_o        = r_valid;
    assign bus.data_o         = r_data;
    assign credits_o          = r_credits;
    assign credit_overflow_o  = r_overflow;

endmodule

`default_nettype wire
